// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: hex/raw decode, per-digit dp and blanking,
// leading-zero suppression, PWM dimming, double-buffered contents applied at frame boundaries.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 200000,
    parameter int PWM_W      = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic [8*NUM_DIGITS-1:0]   data_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic [NUM_DIGITS-1:0]     blank_i,
    input  logic                      mode_i,
    input  logic                      lzs_en_i,
    input  logic [PWM_W-1:0]          bright_i,
    output logic [7:0]                seg_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      frame_done_o
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef struct packed {
        logic [8*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
        logic                    mode;
        logic                    lzs;
    } disp_t;

    logic [PW-1:0]    prescaler;
    logic [DW-1:0]    digit_q;
    logic [PWM_W-1:0] pwm_cnt;
    disp_t            shadow;
    disp_t            active;
    disp_t            incoming;
    logic             pending;

    logic             tick;
    logic             last_digit;
    logic             boundary;

    logic [7:0]            cur_byte;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  suppress;
    logic                  zero_run;
    logic                  lit;
    logic [7:0]            seg_nx;
    logic [NUM_DIGITS-1:0] an_nx;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h7E;
            4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;
            4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;
            4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;
            4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E;
            4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;
            default: hex7 = 7'h47;
        endcase
    endfunction

    assign tick       = (prescaler == PW'(CLK_DIV - 1));
    assign last_digit = (digit_q == DW'(NUM_DIGITS - 1));
    assign boundary   = tick && last_digit;

    assign incoming = '{data: data_i, dp: dp_i, blank: blank_i, mode: mode_i, lzs: lzs_en_i};

    // Walk from the most significant digit down so zero_run holds "this and all higher nibbles are zero".
    always_comb begin
        cur_byte  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        suppress  = 1'b0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (active.data[8*k +: 4] == 4'h0);
            if (DW'(k) == digit_q) begin
                cur_byte  = active.data[8*k +: 8];
                cur_dp    = active.dp[k];
                cur_blank = active.blank[k];
                suppress  = zero_run && (k != 0);
            end
        end

        lit = (bright_i == '1) || (pwm_cnt < bright_i);

        if (cur_blank)
            seg_nx = 8'h00;
        else if (active.mode)
            seg_nx = cur_byte | {cur_dp, 7'b0};
        else if (active.lzs && suppress)
            seg_nx = {cur_dp, 7'b0};
        else
            seg_nx = {cur_dp, hex7(cur_byte[3:0])};

        an_nx = NUM_DIGITS'(1) << digit_q;

        if (!lit) begin
            seg_nx = 8'h00;
            an_nx  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler    <= '0;
            digit_q      <= '0;
            pwm_cnt      <= '0;
            shadow       <= '0;
            active       <= '0;
            pending      <= 1'b0;
            seg_o        <= {8{ACTIVE_LOW}};
            an_o         <= {NUM_DIGITS{ACTIVE_LOW}};
            frame_done_o <= 1'b0;
        end else begin
            pwm_cnt      <= pwm_cnt + 1'b1;
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            frame_done_o <= boundary;
            if (tick)
                digit_q <= last_digit ? '0 : digit_q + 1'b1;

            // A load on the boundary cycle keeps pending set so it lands one frame later.
            if (boundary && pending)
                active <= shadow;
            if (load_i) begin
                shadow  <= incoming;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end

            seg_o <= ACTIVE_LOW ? ~seg_nx : seg_nx;
            an_o  <= ACTIVE_LOW ? ~an_nx : an_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 4-clock slots, active-low outputs.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic        mode_i = 1'b0;
    logic        lzs_en_i = 1'b0;
    logic [3:0]  bright_i = 4'hF;
    logic [7:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_done_o;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS(4),
        .CLK_DIV(4),
        .PWM_W(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_i(load_i),
        .data_i(data_i),
        .dp_i(dp_i),
        .blank_i(blank_i),
        .mode_i(mode_i),
        .lzs_en_i(lzs_en_i),
        .bright_i(bright_i),
        .seg_o(seg_o),
        .an_o(an_o),
        .frame_done_o(frame_done_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // k = clock edges since the last frame boundary (1..16); slot d shows digit d.
    task automatic check_cycle(input string t, input logic [31:0] exp_seg, input int k);
        int d;
        logic [3:0] exp_an;
        d = (k - 1) / 4;
        exp_an = ~(4'b0001 << d);
        check({t, "_an"}, 32'(an_o), 32'(exp_an));
        check({t, "_seg"}, 32'(seg_o), 32'(exp_seg[8*d +: 8]));
        check({t, "_fd"}, 32'(frame_done_o), 32'(k == 16));
    endtask

    task automatic check_frame(input string t, input logic [31:0] exp_seg);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check_cycle(t, exp_seg, k);
        end
    endtask

    task automatic wait_frame(input string t);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done_o) break;
        end
        check({t, "_frame_wait"}, 32'(frame_done_o), 32'd1);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [3:0] dp, input logic [3:0] bl,
                           input logic m, input logic lz);
        data_i   = d;
        dp_i     = dp;
        blank_i  = bl;
        mode_i   = m;
        lzs_en_i = lz;
        load_i   = 1'b1;
        @(negedge clk);
        load_i   = 1'b0;
    endtask

    task automatic count_on(input string t, input logic [3:0] b, input int exp_on);
        int on_cnt;
        int leak;
        on_cnt = 0;
        leak = 0;
        bright_i = b;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an_o != 4'hF) on_cnt++;
            else if (seg_o != 8'hFF) leak++;
        end
        check({t, "_on_cycles"}, 32'(on_cnt), 32'(exp_on));
        check({t, "_seg_when_off"}, 32'(leak), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_an", 32'(an_o), 32'h0000000F);
        check("reset_seg", 32'(seg_o), 32'h000000FF);
        check("reset_fd", 32'(frame_done_o), 32'd0);

        rst_n = 1'b1;
        do_load(32'h0F0A0301, 4'b0000, 4'b0000, 1'b0, 1'b0);
        wait_frame("hex");
        check_frame("hex_f1", 32'hB88886CF);
        check_frame("hex_f2", 32'hB88886CF);

        do_load(32'h00000005, 4'b0000, 4'b0000, 1'b0, 1'b1);
        wait_frame("lzs5");
        check_frame("lzs5", 32'hFFFFFFA4);
        do_load(32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        wait_frame("lzs0");
        check_frame("lzs0", 32'hFFFFFF81);

        do_load(32'h8055013F, 4'b0010, 4'b0100, 1'b1, 1'b0);
        wait_frame("raw");
        check_frame("raw", 32'h7FFF7EC0);

        // Mid-frame load, then a second load landing on the boundary edge.
        do_load(32'h00000402, 4'b0000, 4'b0000, 1'b0, 1'b0);
        check_cycle("dbuf_hold", 32'h7FFF7EC0, 1);
        for (int k = 2; k <= 15; k++) begin
            @(negedge clk);
            check_cycle("dbuf_hold", 32'h7FFF7EC0, k);
        end
        data_i   = 32'h08000000;
        dp_i     = 4'b0001;
        blank_i  = 4'b0000;
        mode_i   = 1'b0;
        lzs_en_i = 1'b0;
        load_i   = 1'b1;
        @(negedge clk);
        load_i   = 1'b0;
        check_cycle("dbuf_hold", 32'h7FFF7EC0, 16);
        check_frame("dbuf_first", 32'h8181CC92);
        check_frame("dbuf_second", 32'h80818101);

        count_on("bright3", 4'd3, 12);
        count_on("bright1", 4'd1, 4);
        count_on("bright0", 4'd0, 0);

        bright_i = 4'hF;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_an", 32'(an_o), 32'h0000000F);
        check("midrst_seg", 32'(seg_o), 32'h000000FF);
        check("midrst_fd", 32'(frame_done_o), 32'd0);
        rst_n = 1'b1;
        check_frame("after_rst", 32'h81818181);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
